sap_cpu_core: RTL and testbench
===============================

# sap_cpu_core

Parametrised successor to the SAP-1 CPU: a multi-cycle accumulator machine with unified program/data memory, generalised in data width and address depth. It adds immediate load, store, and unconditional/conditional jumps on carry and zero. It also adds a host program-load port, an explicit run/halt handshake, and a registered output strobe. It sits under the tt_um top level in place of the fixed 8-bit/16-word core, and is driven by the same clock and reset.

## Interface
- DATA_W, 8: accumulator, B register, memory word and output width; must be >= ADDR_W+4
- ADDR_W, 4: PC/MAR width; memory depth is 2^ADDR_W words
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  sampled only while halted; high starts execution at PC=0
- prog_we  in  1  memory write strobe, honoured only while halted
- prog_addr  in  ADDR_W  write address
- prog_wdata  in  DATA_W  write data
- out_data  out  DATA_W  output register, loaded by OUT
- out_valid  out  1  one-cycle pulse when out_data is updated
- halted  out  1  core is idle and accepting program load/run
- pc  out  ADDR_W  current PC (debug)

## Operation
- Instruction word: opcode is bits [DATA_W-1:DATA_W-4]; operand is bits [ADDR_W-1:0]; other bits are ignored.
- Opcodes:
  - 0 NOP; 1 LDA (A<=M[op]); 2 ADD (A<=A+M[op]); 3 SUB (A<=A-M[op]); 4 STA (M[op]<=A)
  - 5 LDI (A<=operand, zero-extended); 6 JMP; 7 JC (jump if C=1); 8 JZ (jump if Z=1)
  - E OUT; F HLT; 9-D execute as NOP
- Flags C and Z update on ADD and SUB only.
  - ADD: C is the carry-out of the DATA_W-bit sum.
  - SUB: computed as A + ~B + 1; C=1 means no borrow (A>=B).
  - Z = (result==0). The result wraps modulo 2^DATA_W.
- States:
  - HALT: waits for run. On run: PC<=0, C<=0, Z<=0, go to F1.
  - F1: MAR<=PC.
  - F2: IR<=M[MAR]; PC<=PC+1. PC wraps from 2^ADDR_W-1 to 0.
  - E1 (decode):
    - LDA/ADD/SUB/STA: MAR<=operand, go to E2.
    - LDI: A<=operand, go to F1.
    - JMP, or JC/JZ with the condition true: PC<=operand, go to F1. JC/JZ with the condition false: go to F1.
    - OUT: out_data<=A, out_valid<=1, go to F1.
    - HLT: go to HALT.
    - NOP: go to F1.
  - E2:
    - LDA: A<=M[MAR], go to F1.
    - STA: M[MAR]<=A, go to F1.
    - ADD/SUB: B<=M[MAR], go to E3.
  - E3: A<=A±B, update flags, go to F1.
- Cycles per instruction: 3 for NOP/LDI/JMP/JC/JZ/OUT/HLT; 4 for LDA/STA; 5 for ADD/SUB.
- Memory:
  - Register array with combinational read.
  - Not reset; contents survive rst_n.
  - STA may overwrite instructions (self-modifying code is legal).
- Program load:
  - prog_we and run in the same HALT cycle: the write lands, and execution starts the next cycle; F1/F2 see the new word.
  - prog_we while running is ignored. run while running is ignored.

## Timing
- Reset values:
  - State HALT, halted=1.
  - PC, MAR, IR, A, B, C, Z all 0.
  - out_data=0, out_valid=0.
- halted is 1 only in HALT. It falls on the edge that samples run and rises on the edge that completes HLT's E1.
- out_valid is high for exactly one cycle, starting at the edge that completes OUT's E1. Back-to-back OUTs give pulses 3 cycles apart.
- Asserting rst_n low mid-instruction immediately forces the reset values. A partially executed STA/ADD does not commit.

## Test plan
- Add (DATA_W=8, ADDR_W=4):
  - Stimulus: M[0..3]=1E,2F,E0,F0; M[14]=05, M[15]=03; pulse run at edge 0.
  - Response: out_valid for one cycle after edge 12 with out_data=08; halted rises after edge 15; C=0, Z=0.
- Subtract with borrow and not-taken JC:
  - Stimulus: program LDA 14, SUB 15, JC 5, OUT, HLT; M[14]=03, M[15]=05.
  - Response: out_data=FE, C=0; exactly one out_valid pulse.
- Loop with JZ, LDI and STA:
  - Stimulus: LDI 3; STA 15; loop: LDA 15, SUB 14 (M[14]=01), STA 15, OUT, JZ to HLT, JMP loop.
  - Response: out_valid pulses carry 02, 01, 00, then halted; M[15]=00.
- Load gating:
  - Stimulus: prog_we during execution targeting an instruction not yet fetched.
  - Response: memory is unchanged and the original program result is produced.
  - Stimulus: prog_we and run in the same HALT cycle at address 0.
  - Response: the new word executes first.
- Reset mid-ADD:
  - Stimulus: assert rst_n low during E3 of ADD.
  - Response: A=0, flags=0, out_data=0, halted=1; memory intact; rerun reproduces the correct result.
- Wide configuration (DATA_W=12, ADDR_W=8):
  - Stimulus: a 256-word program with NOPs filling to address FF, followed by wrap to address 0 holding HLT.
  - Response: PC wraps FF->00, then halts. ADD of FFF+001 gives A=000, C=1, Z=1.

Source files
------------

// File: rtl/sap_cpu_core.sv
// Parametrised SAP-1 style accumulator CPU: multi-cycle fetch/execute over a
// unified program/data register memory, with host program load and run/halt handshake.
module sap_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_E1   = 3'd3,
    S_E2   = 3'd4,
    S_E3   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [ADDR_W-1:0] pc_r, mar_r, ir_arg_r;
  logic [3:0]        ir_op_r;
  logic [DATA_W-1:0] a_r, b_r, out_data_r;
  logic              c_r, z_r, out_valid_r, halted_r;

  logic              pc_clr_s, pc_inc_s, pc_ld_s, mar_pc_s, mar_op_s, ir_ld_s;
  logic              a_mem_s, a_imm_s, a_alu_s, b_ld_s, flags_clr_s, flags_ld_s;
  logic              out_ld_s, mem_we_s, sub_s;
  logic [DATA_W-1:0] mem_rd_s, alu_b_s;
  logic [DATA_W:0]   alu_sum_s;

  assign mem_rd_s  = mem_r[mar_r];
  // SUB is A + ~B + 1, so the carry-out reads as "no borrow".
  assign sub_s     = (ir_op_r == OP_SUB);
  assign alu_b_s   = sub_s ? ~b_r : b_r;
  assign alu_sum_s = {1'b0, a_r} + {1'b0, alu_b_s} + (DATA_W+1)'(sub_s);

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign halted    = halted_r;
  assign pc        = pc_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_HALT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_HALT: begin
        if (run) state_nxt_s = S_F1;
        else     state_nxt_s = S_HALT;
      end
      S_F1: state_nxt_s = S_F2;
      S_F2: state_nxt_s = S_E1;
      S_E1: begin
        case (ir_op_r)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_nxt_s = S_E2;
          OP_HLT:                         state_nxt_s = S_HALT;
          default:                        state_nxt_s = S_F1;
        endcase
      end
      S_E2: begin
        if (sub_s || (ir_op_r == OP_ADD)) state_nxt_s = S_E3;
        else                              state_nxt_s = S_F1;
      end
      S_E3:    state_nxt_s = S_F1;
      default: state_nxt_s = S_HALT;
    endcase
  end

  // Control decode per state
  always_comb begin
    pc_clr_s = 1'b0; pc_inc_s = 1'b0; pc_ld_s = 1'b0;
    mar_pc_s = 1'b0; mar_op_s = 1'b0; ir_ld_s = 1'b0;
    a_mem_s = 1'b0; a_imm_s = 1'b0; a_alu_s = 1'b0; b_ld_s = 1'b0;
    flags_clr_s = 1'b0; flags_ld_s = 1'b0; out_ld_s = 1'b0; mem_we_s = 1'b0;
    case (state_r)
      S_HALT: begin
        if (run) begin
          pc_clr_s    = 1'b1;
          flags_clr_s = 1'b1;
        end else begin
          pc_clr_s    = 1'b0;
          flags_clr_s = 1'b0;
        end
      end
      S_F1: mar_pc_s = 1'b1;
      S_F2: begin
        ir_ld_s  = 1'b1;
        pc_inc_s = 1'b1;
      end
      S_E1: begin
        case (ir_op_r)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_op_s = 1'b1;
          OP_LDI:  a_imm_s  = 1'b1;
          OP_JMP:  pc_ld_s  = 1'b1;
          OP_JC:   pc_ld_s  = c_r;
          OP_JZ:   pc_ld_s  = z_r;
          OP_OUT:  out_ld_s = 1'b1;
          default: out_ld_s = 1'b0;
        endcase
      end
      S_E2: begin
        case (ir_op_r)
          OP_LDA:         a_mem_s  = 1'b1;
          OP_STA:         mem_we_s = 1'b1;
          OP_ADD, OP_SUB: b_ld_s   = 1'b1;
          default:        b_ld_s   = 1'b0;
        endcase
      end
      S_E3: begin
        a_alu_s    = 1'b1;
        flags_ld_s = 1'b1;
      end
      default: a_alu_s = 1'b0;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= '0;
      mar_r       <= '0;
      ir_op_r     <= 4'h0;
      ir_arg_r    <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= 1'b0;
      z_r         <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b1;
    end else begin
      if (pc_clr_s)      pc_r <= '0;
      else if (pc_ld_s)  pc_r <= ir_arg_r;
      else if (pc_inc_s) pc_r <= pc_r + ADDR_W'(1);
      if (mar_pc_s)      mar_r <= pc_r;
      else if (mar_op_s) mar_r <= ir_arg_r;
      if (ir_ld_s) begin
        ir_op_r  <= mem_rd_s[DATA_W-1 -: 4];
        ir_arg_r <= mem_rd_s[ADDR_W-1:0];
      end
      if (a_mem_s)      a_r <= mem_rd_s;
      else if (a_imm_s) a_r <= DATA_W'(ir_arg_r);
      else if (a_alu_s) a_r <= alu_sum_s[DATA_W-1:0];
      if (b_ld_s) b_r <= mem_rd_s;
      if (flags_clr_s) begin
        c_r <= 1'b0;
        z_r <= 1'b0;
      end else if (flags_ld_s) begin
        c_r <= alu_sum_s[DATA_W];
        z_r <= (alu_sum_s[DATA_W-1:0] == '0);
      end
      if (out_ld_s) out_data_r <= a_r;
      out_valid_r <= out_ld_s;
      halted_r    <= (state_nxt_s == S_HALT);
    end
  end

  // Unified memory: host writes only while halted; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (prog_we && (state_r == S_HALT)) begin
      mem_r[prog_addr] <= prog_wdata;
    end else if (mem_we_s) begin
      mem_r[mar_r] <= a_r;
    end
  end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed bench for sap_cpu_core: table of 8-bit programs plus hand-written
// sequences for cycle timing, load gating, reset mid-instruction and a wide config.
module tb_sap_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n, run, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_wdata, out_data;
  logic        out_valid, halted;
  logic [3:0]  pc;

  logic        w_run, w_prog_we;
  logic [7:0]  w_prog_addr, w_pc;
  logic [11:0] w_prog_wdata, w_out_data;
  logic        w_out_valid, w_halted;

  int tests = 0;
  int fails = 0;

  logic [7:0]  outq [$];
  logic [11:0] w_outq [$];
  bit          w_saw_ff = 1'b0;
  bit          w_wrapped = 1'b0;

  typedef struct packed {
    logic [127:0] prog;   // word i at bits [8*i +: 8]
    logic [2:0]   nout;
    logic [31:0]  outs;   // pulse j at bits [8*j +: 8]
    logic         c;
    logic         z;
    logic [7:0]   m15;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .out_data(out_data), .out_valid(out_valid), .halted(halted), .pc(pc)
  );

  sap_cpu_core #(.DATA_W(12), .ADDR_W(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .run(w_run), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_wdata(w_prog_wdata),
    .out_data(w_out_data), .out_valid(w_out_valid), .halted(w_halted), .pc(w_pc)
  );

  // Output pulse collection and PC wrap observation
  always @(negedge clk) begin
    if (out_valid) outq.push_back(out_data);
    if (w_out_valid) w_outq.push_back(w_out_data);
    if (w_pc == 8'hFF) w_saw_ff = 1'b1;
    else if (w_saw_ff && (w_pc == 8'h00)) w_wrapped = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load8(input logic [127:0] p);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = p[8*i +: 8];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (halted) break;
      @(negedge clk);
    end
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic run8(input string name);
    outq.delete();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_halt(name, 400);
  endtask

  initial begin
    logic [127:0] p_add;
    logic [7:0]   got;
    logic [11:0]  wprog [256];

    rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_wdata = 8'h00;
    w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = 8'h00; w_prog_wdata = 12'h000;

    p_add = {8'h03, 8'h05, 80'h0, 8'hF0, 8'hE0, 8'h2F, 8'h1E};
    vecs[0] = '{prog: p_add, nout: 3'd1, outs: 32'h0000_0008, c: 1'b0, z: 1'b0, m15: 8'h03};
    vecs[1] = '{prog: {8'h05, 8'h03, 64'h0, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h3F, 8'h1E},
                nout: 3'd1, outs: 32'h0000_00FE, c: 1'b0, z: 1'b0, m15: 8'h05};
    vecs[2] = '{prog: {8'h00, 8'h01, 40'h0, 8'hF0, 8'h62, 8'h88, 8'hE0, 8'h4F,
                       8'h3E, 8'h1F, 8'h4F, 8'h53},
                nout: 3'd3, outs: 32'h0000_0102, c: 1'b1, z: 1'b1, m15: 8'h00};
    vecs[3] = '{prog: {8'h00, 8'hF1, 40'h0, 8'hF0, 8'hE0, 8'h9A, 8'h57, 8'hF0,
                       8'h75, 8'hE0, 8'h2E, 8'h5F},
                nout: 3'd2, outs: 32'h0000_0700, c: 1'b1, z: 1'b1, m15: 8'h00};

    repeat (3) @(negedge clk);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_wide_halted", {31'd0, w_halted}, 32'd1);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      load8(vecs[v].prog);
      run8($sformatf("vec%0d_halt", v));
      check($sformatf("vec%0d_nout", v), outq.size(), {29'd0, vecs[v].nout});
      for (int j = 0; j < int'(vecs[v].nout); j++) begin
        got = (j < outq.size()) ? outq[j] : 8'hXX;
        check($sformatf("vec%0d_out%0d", v, j), {24'd0, got}, {24'd0, vecs[v].outs[8*j +: 8]});
      end
      check($sformatf("vec%0d_c", v), {31'd0, dut.c_r}, {31'd0, vecs[v].c});
      check($sformatf("vec%0d_z", v), {31'd0, dut.z_r}, {31'd0, vecs[v].z});
      check($sformatf("vec%0d_m15", v), {24'd0, dut.mem_r[15]}, {24'd0, vecs[v].m15});
    end

    // Cycle timing of the add program: OUT pulse after edge 12, halt after edge 15
    load8(p_add);
    @(negedge clk); run = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) run = 1'b0;
      check($sformatf("tim_valid_e%0d", k), {31'd0, out_valid}, {31'd0, k == 12});
      check($sformatf("tim_halted_e%0d", k), {31'd0, halted}, {31'd0, k >= 15});
      if (k == 12) check("tim_out_data", {24'd0, out_data}, 32'h08);
    end

    // Host write while running is dropped
    outq.delete();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0; prog_we = 1'b1; prog_addr = 4'd3; prog_wdata = 8'hE0;
    @(negedge clk); prog_we = 1'b0;
    wait_halt("gate_halt", 400);
    check("gate_nout", outq.size(), 32'd1);
    check("gate_out", {24'd0, (outq.size() > 0) ? outq[0] : 8'hXX}, 32'h08);
    check("gate_mem3", {24'd0, dut.mem_r[3]}, 32'hF0);

    // Write and run in the same halted cycle: LDI 7 replaces LDA 14, giving 7+3
    outq.delete();
    @(negedge clk); prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 8'h57; run = 1'b1;
    @(negedge clk); prog_we = 1'b0; run = 1'b0;
    wait_halt("same_halt", 400);
    check("same_nout", outq.size(), 32'd1);
    check("same_out", {24'd0, (outq.size() > 0) ? outq[0] : 8'hXX}, 32'h0A);

    // Reset during E3 of ADD (between edges 8 and 9)
    load8(p_add);
    outq.delete();
    @(negedge clk); run = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) run = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_a", {24'd0, dut.a_r}, 32'd0);
    check("mid_c", {31'd0, dut.c_r}, 32'd0);
    check("mid_z", {31'd0, dut.z_r}, 32'd0);
    check("mid_out_data", {24'd0, out_data}, 32'd0);
    check("mid_halted", {31'd0, halted}, 32'd1);
    check("mid_pc", {28'd0, pc}, 32'd0);
    check("mid_nout", outq.size(), 32'd0);
    check("mid_mem14", {24'd0, dut.mem_r[14]}, 32'h05);
    @(negedge clk); rst_n = 1'b1;
    run8("mid_rerun_halt");
    check("mid_rerun_nout", outq.size(), 32'd1);
    check("mid_rerun_out", {24'd0, (outq.size() > 0) ? outq[0] : 8'hXX}, 32'h08);

    // Wide core: FFF+001 flags, then self-patched HLT at 0 reached via PC wrap
    for (int i = 0; i < 256; i++) wprog[i] = 12'h000;
    wprog[0] = 12'h500; wprog[1] = 12'h3F0; wprog[2] = 12'hE00; wprog[3] = 12'h2F0;
    wprog[4] = 12'h706; wprog[5] = 12'hF00; wprog[6] = 12'h808; wprog[7] = 12'hF00;
    wprog[8] = 12'hE00; wprog[9] = 12'h105; wprog[10] = 12'h400; wprog[240] = 12'h001;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      w_prog_we = 1'b1; w_prog_addr = 8'(i); w_prog_wdata = wprog[i];
    end
    @(negedge clk); w_prog_we = 1'b0;
    w_outq.delete();
    @(negedge clk); w_run = 1'b1;
    @(negedge clk); w_run = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (w_halted) break;
      @(negedge clk);
    end
    check("wide_halt", {31'd0, w_halted}, 32'd1);
    check("wide_nout", w_outq.size(), 32'd2);
    check("wide_out0", {20'd0, (w_outq.size() > 0) ? w_outq[0] : 12'hXXX}, 32'hFFF);
    check("wide_out1", {20'd0, (w_outq.size() > 1) ? w_outq[1] : 12'hXXX}, 32'h000);
    check("wide_wrap", {31'd0, w_wrapped}, 32'd1);
    check("wide_pc", {24'd0, w_pc}, 32'h01);
    check("wide_c", {31'd0, u_wide.c_r}, 32'd1);
    check("wide_z", {31'd0, u_wide.z_r}, 32'd1);
    check("wide_a", {20'd0, u_wide.a_r}, 32'hF00);
    check("wide_mem0", {20'd0, u_wide.mem_r[0]}, 32'hF00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
